// File: rtl/joy_dir_pkg.sv
// rtl/joy_dir_pkg.sv - shared modes, direction indices and one-hot helpers for joy_dir_filter
package joy_dir_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_ONEDIR = 2'd1,
    MODE_SOCD   = 2'd2
  } mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  // Helpers work on a fixed-width vector; channels zero-extend into it.
  localparam int MAX_DIRS  = 16;
  localparam int DIR_IDX_W = 4;

  typedef logic [MAX_DIRS-1:0]  dir_vec_t;
  typedef logic [DIR_IDX_W-1:0] dir_idx_t;

  function automatic dir_idx_t hi_index(input dir_vec_t vec);
    dir_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_DIRS; i++) begin
      if (vec[i]) idx = dir_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic dir_vec_t hi_onehot(input dir_vec_t vec);
    dir_vec_t oh;
    oh = '0;
    if (vec != '0) oh[hi_index(vec)] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/joy_dir_chan.sv
// rtl/joy_dir_chan.sv - one player: sync, debounce, press edge, ONEDIR lock FSM, output register
// JOYDIR_STICKY_EN: ONEDIR remembers the previously locked direction and falls back to it on release.
module joy_dir_chan
  import joy_dir_pkg::*;
#(
  parameter int NUM_DIRS        = 4,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  input  logic [NUM_DIRS-1:0] in_dir,
  output logic [NUM_DIRS-1:0] out_dir,
  output logic                out_chg
);

  logic [NUM_DIRS-1:0] s1, s2, db, db_prev, out_d;
  dir_vec_t            db_w, new_w, mask_d, clr_w;
  lock_state_t         state_q, state_d;
  dir_idx_t            cur_q, cur_d;
`ifdef JOYDIR_STICKY_EN
  dir_idx_t            prv_q, prv_d;
  logic                prv_v_q, prv_v_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      db_prev <= '0;
    end else begin
      s1      <= in_dir;
      s2      <= s1;
      db_prev <= db;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
      assign db = s2;
    end else begin : g_db
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0]    cnt [NUM_DIRS];
      logic [NUM_DIRS-1:0] db_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          db_q <= '0;
          for (int i = 0; i < NUM_DIRS; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_DIRS; i++) begin
            if (s2[i] == db_q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] >= CNT_LAST) begin
              db_q[i] <= s2[i];
              cnt[i]  <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end
      assign db = db_q;
    end
  endgenerate

  assign db_w  = dir_vec_t'(db);
  assign new_w = dir_vec_t'(db & ~db_prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
`ifdef JOYDIR_STICKY_EN
      prv_q   <= '0;
      prv_v_q <= 1'b0;
`endif
      out_dir <= '0;
      out_chg <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
`ifdef JOYDIR_STICKY_EN
      prv_q   <= prv_d;
      prv_v_q <= prv_v_d;
`endif
      out_dir <= out_d;
      out_chg <= (out_d != out_dir);
    end
  end

  // A fresh press always wins over a release seen on the same cycle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
`ifdef JOYDIR_STICKY_EN
    prv_d   = prv_q;
    prv_v_d = prv_v_q;
`endif
    if (mode != MODE_ONEDIR) begin
      state_d = ST_IDLE;
`ifdef JOYDIR_STICKY_EN
      prv_v_d = 1'b0;
`endif
    end else if (new_w != '0) begin
      state_d = ST_LOCKED;
      cur_d   = hi_index(new_w);
`ifdef JOYDIR_STICKY_EN
      prv_d   = cur_q;
      prv_v_d = (state_q == ST_LOCKED);
`endif
    end else if (state_q == ST_LOCKED && !db_w[cur_q]) begin
`ifdef JOYDIR_STICKY_EN
      prv_v_d = 1'b0;
      if (prv_v_q && db_w[prv_q]) cur_d = prv_q;
      else                        state_d = ST_IDLE;
`else
      state_d = ST_IDLE;
`endif
    end

    mask_d = (state_d == ST_IDLE) ? '1 : (dir_vec_t'(1) << cur_d);

    clr_w = '0;
    if (NUM_DIRS >= 4) begin
      if (db_w[DIR_RIGHT] && db_w[DIR_LEFT]) begin
        clr_w[DIR_RIGHT] = 1'b1;
        clr_w[DIR_LEFT]  = 1'b1;
      end
      if (db_w[DIR_DOWN] && db_w[DIR_UP]) begin
        clr_w[DIR_DOWN] = 1'b1;
        clr_w[DIR_UP]   = 1'b1;
      end
    end

    case (mode)
      MODE_ONEDIR: out_d = NUM_DIRS'(hi_onehot(db_w & mask_d));
      MODE_SOCD:   out_d = NUM_DIRS'(db_w & ~clr_w);
      default:     out_d = db;
    endcase
  end

endmodule

// File: rtl/joy_dir_filter.sv
// rtl/joy_dir_filter.sv - multi-player joystick direction conditioner (top)
// JOYDIR_STICKY_EN selects the sticky ONEDIR history inside each channel.
module joy_dir_filter #(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_DIRS        = 4,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [2*NUM_PLAYERS-1:0]        mode,
  input  logic [NUM_PLAYERS*NUM_DIRS-1:0] in_dir,
  output logic [NUM_PLAYERS*NUM_DIRS-1:0] out_dir,
  output logic [NUM_PLAYERS-1:0]          out_chg
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    joy_dir_chan #(
      .NUM_DIRS        (NUM_DIRS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .mode    (mode[2*p +: 2]),
      .in_dir  (in_dir[p*NUM_DIRS +: NUM_DIRS]),
      .out_dir (out_dir[p*NUM_DIRS +: NUM_DIRS]),
      .out_chg (out_chg[p])
    );
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// tb/tb_joy_dir_filter.sv - scoreboard bench for joy_dir_filter (bypass and 4-cycle debounce builds)
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] mode_a, mode_b;
  logic [7:0] in_a, in_b, out_a, out_b;
  logic [1:0] chg_a, chg_b;

  joy_dir_filter #(.NUM_PLAYERS(2), .NUM_DIRS(4), .DEBOUNCE_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode_a), .in_dir(in_a),
    .out_dir(out_a), .out_chg(chg_a)
  );

  joy_dir_filter #(.NUM_PLAYERS(2), .NUM_DIRS(4), .DEBOUNCE_CYCLES(4)) dut_db (
    .clk(clk), .reset_n(reset_n), .mode(mode_b), .in_dir(in_b),
    .out_dir(out_b), .out_chg(chg_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         due;
    bit         sel;
    logic [7:0] out;
    logic [1:0] chg;
    string      tag;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input bit sel, input int delta, input logic [7:0] o,
                           input logic [1:0] c, input string tag);
    exp_t e;
    e.due = cyc + delta;
    e.sel = sel;
    e.out = o;
    e.chg = c;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [7:0] v, input logic [7:0] o, input logic [1:0] c,
                      input string tag);
    in_a = v;
    expect_at(1'b0, 3, o, c, tag);
    expect_at(1'b0, 4, o, 2'b00, {tag, "_hold"});
    tick(6);
  endtask

  task automatic set_mode(input logic [3:0] m, input logic [7:0] o, input logic [1:0] c,
                          input string tag);
    mode_a = m;
    expect_at(1'b0, 1, o, c, tag);
    expect_at(1'b0, 2, o, 2'b00, {tag, "_hold"});
    tick(6);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due != cyc) check_val({e.tag, "_late"}, cyc, e.due);
      check_val({e.tag, "_out"}, e.sel ? out_b : out_a, e.out);
      check_val({e.tag, "_chg"}, e.sel ? chg_b : chg_a, e.chg);
    end
  end

  initial begin
    reset_n = 1'b0;
    in_a    = 8'hFF;
    in_b    = 8'h00;
    mode_a  = 4'b0000;
    mode_b  = 4'b0000;
    tick(2);
    check_val("rst_out_a", out_a, 8'h00);
    check_val("rst_chg_a", chg_a, 2'b00);
    check_val("rst_out_b", out_b, 8'h00);

    reset_n = 1'b1;
    expect_at(1'b0, 2, 8'h00, 2'b00, "pass_lat2");
    expect_at(1'b0, 3, 8'hFF, 2'b11, "pass_all");
    expect_at(1'b0, 4, 8'hFF, 2'b00, "pass_all_hold");
    tick(6);
    step(8'h00, 8'h00, 2'b11, "pass_zero");

    set_mode(4'b0001, 8'h00, 2'b00, "to_onedir");
    step(8'h08, 8'h08, 2'b01, "od_up");
    step(8'h0A, 8'h02, 2'b01, "od_left");
    step(8'h0B, 8'h01, 2'b01, "od_right");
`ifdef JOYDIR_STICKY_EN
    step(8'h0A, 8'h02, 2'b01, "od_rel_right");
    step(8'h08, 8'h08, 2'b01, "od_rel_left");
`else
    step(8'h0A, 8'h08, 2'b01, "od_rel_right");
    step(8'h08, 8'h08, 2'b00, "od_rel_left");
`endif
    step(8'h00, 8'h00, 2'b01, "od_none");
    step(8'h05, 8'h04, 2'b01, "od_simul");
    step(8'h09, 8'h08, 2'b01, "od_swap");
    step(8'h0A, 8'h02, 2'b01, "od_lock_left");

    set_mode(4'b0000, 8'h0A, 2'b01, "sw_pass");
    set_mode(4'b0001, 8'h08, 2'b01, "sw_onedir");
    set_mode(4'b0010, 8'h0A, 2'b01, "sw_socd");

    step(8'hF3, 8'hF0, 2'b11, "socd_lr");
    step(8'hFE, 8'hF2, 2'b01, "socd_ud");
    step(8'hFF, 8'hF0, 2'b01, "socd_all");

    in_b = 8'h01;
    expect_at(1'b1, 7, 8'h00, 2'b00, "db_pulse7");
    expect_at(1'b1, 8, 8'h00, 2'b00, "db_pulse8");
    tick(3);
    in_b = 8'h00;
    tick(10);

    in_b = 8'h01;
    expect_at(1'b1, 6, 8'h00, 2'b00, "db_hold6");
    expect_at(1'b1, 7, 8'h01, 2'b01, "db_hold7");
    expect_at(1'b1, 8, 8'h01, 2'b00, "db_hold8");
    tick(10);
    in_b = 8'h00;
    expect_at(1'b1, 6, 8'h01, 2'b00, "db_rel6");
    expect_at(1'b1, 7, 8'h00, 2'b01, "db_rel7");
    tick(10);

    check_val("sb_drain", sb.size(), 0);

    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_out_a", out_a, 8'h00);
    check_val("async_rst_chg_a", chg_a, 2'b00);
    check_val("async_rst_out_b", out_b, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
